// File: rtl/watch_pkg.sv
// watch_pkg: shared definitions for the watch/stopwatch control front-end.
//   - state_t    : run/pause/idle FSM encoding (value 3 is illegal, recovers to IDLE)
//   - calc_div() : prescaler divide ratio from clock and tick frequencies
package watch_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ILL   = 2'd3
    } state_t;

    function automatic int calc_div(input int clk_freq, input int tick_freq);
        return clk_freq / tick_freq;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counter debounce and press-pulse generator
// for one raw push-button.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : raw asynchronous button level
//   press      : one-cycle pulse on each debounced rising edge (release gives none)
module btn_debounce
    import watch_pkg::*;
#(
    parameter int P_DEB_CYCLES = 1_000_000,
    parameter int P_DEB_BIT    = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [P_DEB_BIT-1:0] DEB_MAX = P_DEB_BIT'(P_DEB_CYCLES - 1);

    logic                 sync1, sync2;
    logic                 level, level_d;
    logic [P_DEB_BIT-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any cycle of agreement restarts the stability window, so a
            // bounce shorter than the window never moves the level.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_MAX) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_run_ctrl.sv
// watch_run_ctrl: run/pause/idle control for the stopwatch counter chain.
// Debounces Start/Stop and Clear, runs the state machine and a base-tick
// prescaler that only advances while running.
//   clk, reset  : system clock, synchronous active-high reset
//   i_btn_start : raw Start/Stop button
//   i_btn_clear : raw Clear button
//   o_run_en    : high while in RUN
//   o_tick      : one-cycle base tick, every DIV cycles of RUN
//   o_clear     : one-cycle pulse clearing the downstream counters
//   o_state     : current FSM state
// Optional (macro WATCH_LAP_EN): i_btn_lap / o_lap_hold lap-freeze control.
module watch_run_ctrl
    import watch_pkg::*;
#(
    parameter int P_CLK_FREQ   = 100_000_000,
    parameter int P_TICK_FREQ  = 100,
    parameter int P_DIV_BIT    = 20,
    parameter int P_DEB_CYCLES = 1_000_000,
    parameter int P_DEB_BIT    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_start,
    input  logic       i_btn_clear,
    output logic       o_run_en,
    output logic       o_tick,
    output logic       o_clear,
    output logic [1:0] o_state
`ifdef WATCH_LAP_EN
    ,
    input  logic       i_btn_lap,
    output logic       o_lap_hold
`endif
);

    localparam int                   DIV     = calc_div(P_CLK_FREQ, P_TICK_FREQ);
    localparam logic [P_DIV_BIT-1:0] DIV_MAX = P_DIV_BIT'(DIV - 1);

    logic start_p, clear_p;

    btn_debounce #(.P_DEB_CYCLES(P_DEB_CYCLES), .P_DEB_BIT(P_DEB_BIT)) u_deb_start (
        .clk(clk), .reset(reset), .btn(i_btn_start), .press(start_p)
    );

    btn_debounce #(.P_DEB_CYCLES(P_DEB_CYCLES), .P_DEB_BIT(P_DEB_BIT)) u_deb_clear (
        .clk(clk), .reset(reset), .btn(i_btn_clear), .press(clear_p)
    );

`ifdef WATCH_LAP_EN
    logic lap_p;

    btn_debounce #(.P_DEB_CYCLES(P_DEB_CYCLES), .P_DEB_BIT(P_DEB_BIT)) u_deb_lap (
        .clk(clk), .reset(reset), .btn(i_btn_lap), .press(lap_p)
    );
`endif

    state_t               state, st_nxt;
    logic                 clr_nxt;
    logic [P_DIV_BIT-1:0] div_cnt;

    // Priority: in RUN start beats clear (clear is ignored there anyway);
    // in IDLE/PAUSE clear beats start.
    always_comb begin
        st_nxt  = state;
        clr_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clear_p)      clr_nxt = 1'b1;
                else if (start_p) st_nxt  = ST_RUN;
            end
            ST_RUN: begin
                if (start_p) st_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear_p) begin
                    st_nxt  = ST_IDLE;
                    clr_nxt = 1'b1;
                end else if (start_p) begin
                    st_nxt = ST_RUN;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            o_run_en <= 1'b0;
            o_state  <= 2'd0;
            o_clear  <= 1'b0;
            o_tick   <= 1'b0;
            div_cnt  <= '0;
        end else begin
            state    <= st_nxt;
            o_run_en <= (st_nxt == ST_RUN);
            o_state  <= st_nxt;
            o_clear  <= clr_nxt;
            // Count advances on every edge spent in RUN, including the one
            // that leaves it, so a resume continues the partial period.
            if (st_nxt == ST_IDLE) begin
                div_cnt <= '0;
            end else if (state == ST_RUN) begin
                div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
            end
            // A wrap on the edge that enters PAUSE produces no tick.
            o_tick <= (state == ST_RUN) && (div_cnt == DIV_MAX) && (st_nxt == ST_RUN);
        end
    end

`ifdef WATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_lap_hold <= 1'b0;
        end else if (st_nxt == ST_IDLE) begin
            o_lap_hold <= 1'b0;
        end else if (state == ST_RUN && lap_p) begin
            o_lap_hold <= ~o_lap_hold;
        end
    end
`endif

endmodule
